segre_csr_unit: RTL and testbench

Machine-mode control and status register unit for the Segre core, replacing the flat CSR array with a decoded RISC-V CSR set. Executes CSRRW/CSRRS/CSRRC read-modify-write operations, maintains parametrised-width cycle and retired-instruction counters, and absorbs trap entry and return updates from the pipeline. Sits beside the execute stage: operands arrive from decode, and read data returns to writeback.

---
 rtl/segre_csr_unit_if.sv | 25 ++
 rtl/segre_csr_unit.sv | 237 +++++++++++++++++++++++
 tb/tb_segre_csr_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/segre_csr_unit_if.sv
// CSR access bus between the execute stage and segre_csr_unit.
// Names are from the CSR unit's point of view (_i into it, _o out of it).
interface segre_csr_unit_if;
    logic [1:0]  op_i;
    logic [11:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        illegal_o;

    modport master (
        output op_i,
        output addr_i,
        output wdata_i,
        input  rdata_o,
        input  illegal_o
    );

    modport slave (
        input  op_i,
        input  addr_i,
        input  wdata_i,
        output rdata_o,
        output illegal_o
    );
endinterface

// File: rtl/segre_csr_unit.sv
// Machine-mode CSR unit: CSRRW/S/C, mcycle/minstret, trap entry and MRET.
// Define SEGRE_CSR_MCOUNTINHIBIT_EN to implement mcountinhibit at 0x320.
module segre_csr_unit #(
    parameter int unsigned COUNTER_WIDTH = 64,
    parameter int unsigned NUM_SCRATCH   = 1,
    parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rsn_i,
    segre_csr_unit_if.slave        csr,
    input  logic                   instret_i,
    input  logic                   trap_i,
    input  logic [31:0]            trap_epc_i,
    input  logic [31:0]            trap_cause_i,
    input  logic                   mret_i,
    output logic [31:0]            mtvec_o,
    output logic [31:0]            mepc_o,
    output logic                   mie_o
);

    localparam int unsigned CW = COUNTER_WIDTH;
    localparam int unsigned HW = CW - 32;
    localparam logic [CW-1:0] CNT_ONE = 1;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_SCR_BASE  = 12'h7C0;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
`ifdef SEGRE_CSR_MCOUNTINHIBIT_EN
    localparam logic [11:0] A_MCNTINH   = 12'h320;
`endif

    logic                mie_q, mie_d;
    logic                mpie_q, mpie_d;
    logic [31:0]         mtvec_q, mtvec_d;
    logic [31:0]         mscratch_q, mscratch_d;
    logic [31:0]         mepc_q, mepc_d;
    logic [31:0]         mcause_q, mcause_d;
    logic [31:0]         scratch_q [NUM_SCRATCH];
    logic [31:0]         scratch_d [NUM_SCRATCH];
    logic [CW-1:0]       mcycle_q, mcycle_d;
    logic [CW-1:0]       minstret_q, minstret_d;
    logic                cy_inh, ir_inh;

`ifdef SEGRE_CSR_MCOUNTINHIBIT_EN
    logic                cy_q, cy_d;
    logic                ir_q, ir_d;
    assign cy_inh = cy_q;
    assign ir_inh = ir_q;
`else
    assign cy_inh = 1'b0;
    assign ir_inh = 1'b0;
`endif

    logic [31:0] mstatus;
    logic [31:0] cych;
    logic [31:0] insth;
    logic [31:0] rdata;
    logic [31:0] new_val;
    logic        impl;
    logic        ro;
    logic        wr_intent;
    logic        illegal;
    logic        we;

    assign mstatus = {24'b0, mpie_q, 3'b0, mie_q, 3'b0};
    assign cych    = 32'(mcycle_q[CW-1:32]);
    assign insth   = 32'(minstret_q[CW-1:32]);

    always_comb begin
        rdata = '0;
        impl  = 1'b1;
        case (csr.addr_i)
            A_MSTATUS:              rdata = mstatus;
            A_MTVEC:                rdata = mtvec_q;
            A_MSCRATCH:             rdata = mscratch_q;
            A_MEPC:                 rdata = mepc_q;
            A_MCAUSE:               rdata = mcause_q;
            A_MCYCLE,   A_CYCLE:    rdata = mcycle_q[31:0];
            A_MCYCLEH,  A_CYCLEH:   rdata = cych;
            A_MINSTRET, A_INSTRET:  rdata = minstret_q[31:0];
            A_MINSTRETH, A_INSTRETH: rdata = insth;
`ifdef SEGRE_CSR_MCOUNTINHIBIT_EN
            A_MCNTINH:              rdata = {29'b0, ir_q, 1'b0, cy_q};
`endif
            default: begin
                impl = 1'b0;
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (csr.addr_i == A_SCR_BASE + 12'(i)) begin
                        rdata = scratch_q[i];
                        impl  = 1'b1;
                    end
                end
            end
        endcase
    end

    // Set/clear with a zero mask is a pure read, even of read-only CSRs.
    assign ro        = csr.addr_i[11:10] == 2'b11;
    assign wr_intent = (csr.op_i == OP_WRITE) ||
                       ((csr.op_i != OP_NONE) && (csr.wdata_i != '0));
    assign illegal   = (csr.op_i != OP_NONE) && (!impl || (wr_intent && ro));
    assign we        = wr_intent && !illegal && !trap_i;

    always_comb begin
        case (csr.op_i)
            OP_WRITE: new_val = csr.wdata_i;
            OP_SET:   new_val = rdata | csr.wdata_i;
            OP_CLEAR: new_val = rdata & ~csr.wdata_i;
            default:  new_val = rdata;
        endcase
    end

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        scratch_d  = scratch_q;
`ifdef SEGRE_CSR_MCOUNTINHIBIT_EN
        cy_d       = cy_q;
        ir_d       = ir_q;
`endif
        if (we) begin
            case (csr.addr_i)
                A_MSTATUS: begin
                    mie_d  = new_val[3];
                    mpie_d = new_val[7];
                end
                A_MTVEC:    mtvec_d    = {new_val[31:2], 2'b00};
                A_MSCRATCH: mscratch_d = new_val;
                A_MEPC:     mepc_d     = {new_val[31:2], 2'b00};
                A_MCAUSE:   mcause_d   = new_val;
`ifdef SEGRE_CSR_MCOUNTINHIBIT_EN
                A_MCNTINH: begin
                    cy_d = new_val[0];
                    ir_d = new_val[2];
                end
`endif
                default: begin
                    for (int i = 0; i < NUM_SCRATCH; i++) begin
                        if (csr.addr_i == A_SCR_BASE + 12'(i))
                            scratch_d[i] = new_val;
                    end
                end
            endcase
        end
        // Trap beats MRET, and MRET beats a software mstatus write.
        if (trap_i) begin
            mepc_d   = {trap_epc_i[31:2], 2'b00};
            mcause_d = trap_cause_i;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret_i) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
    end

    always_comb begin
        mcycle_d = mcycle_q;
        if (we && csr.addr_i == A_MCYCLE)
            mcycle_d[31:0] = new_val;
        else if (we && csr.addr_i == A_MCYCLEH)
            mcycle_d[CW-1:32] = new_val[HW-1:0];
        else if (!cy_inh)
            mcycle_d = mcycle_q + CNT_ONE;
    end

    always_comb begin
        minstret_d = minstret_q;
        if (we && csr.addr_i == A_MINSTRET)
            minstret_d[31:0] = new_val;
        else if (we && csr.addr_i == A_MINSTRETH)
            minstret_d[CW-1:32] = new_val[HW-1:0];
        else if (instret_i && !ir_inh)
            minstret_d = minstret_q + CNT_ONE;
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
            for (int i = 0; i < NUM_SCRATCH; i++)
                scratch_q[i] <= '0;
`ifdef SEGRE_CSR_MCOUNTINHIBIT_EN
            cy_q       <= 1'b0;
            ir_q       <= 1'b0;
`endif
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            for (int i = 0; i < NUM_SCRATCH; i++)
                scratch_q[i] <= scratch_d[i];
`ifdef SEGRE_CSR_MCOUNTINHIBIT_EN
            cy_q       <= cy_d;
            ir_q       <= ir_d;
`endif
        end
    end

    assign csr.rdata_o   = rdata;
    assign csr.illegal_o = illegal;
    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;
    assign mie_o         = mie_q;

endmodule

// File: tb/tb_segre_csr_unit.sv
// Self-checking bench for segre_csr_unit: vector table, directed corner
// sequences and random traffic against an architectural CSR model.
module tb_segre_csr_unit;

    localparam int unsigned CW = 40;
    localparam int unsigned NS = 2;
    localparam logic [31:0] MTV = 32'h0000_1000;
    localparam logic [63:0] CMASK = (64'd1 << CW) - 64'd1;

    logic        clk = 1'b0;
    logic        rsn = 1'b0;
    logic        instret = 1'b0;
    logic        trap = 1'b0;
    logic        mret = 1'b0;
    logic [31:0] epc = '0;
    logic [31:0] cause = '0;
    logic [31:0] mtvec_w, mepc_w;
    logic        mie_w;

    segre_csr_unit_if bus ();

    segre_csr_unit #(
        .COUNTER_WIDTH(CW),
        .NUM_SCRATCH  (NS),
        .MTVEC_RESET  (MTV)
    ) dut (
        .clk_i       (clk),
        .rsn_i       (rsn),
        .csr         (bus),
        .instret_i   (instret),
        .trap_i      (trap),
        .trap_epc_i  (epc),
        .trap_cause_i(cause),
        .mret_i      (mret),
        .mtvec_o     (mtvec_w),
        .mepc_o      (mepc_w),
        .mie_o       (mie_w)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Architectural model state
    logic        m_mie, m_mpie, m_cy, m_ir;
    logic [31:0] m_mtvec, m_mscr, m_mepc, m_mcause;
    logic [31:0] m_scr [NS];
    logic [63:0] m_cyc, m_ins;

    task automatic m_reset();
        m_mie = 0; m_mpie = 0; m_cy = 0; m_ir = 0;
        m_mtvec = MTV; m_mscr = 0; m_mepc = 0; m_mcause = 0;
        m_cyc = 0; m_ins = 0;
        for (int i = 0; i < NS; i++) m_scr[i] = 0;
    endtask

    function automatic logic m_impl(input logic [11:0] a);
        case (a)
            12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
            12'hB00, 12'hB80, 12'hB02, 12'hB82,
            12'hC00, 12'hC80, 12'hC02, 12'hC82: return 1'b1;
`ifdef SEGRE_CSR_MCOUNTINHIBIT_EN
            12'h320: return 1'b1;
`endif
            default: return (a >= 12'h7C0) && (a < 12'h7C0 + 12'(NS));
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return {24'b0, m_mpie, 3'b0, m_mie, 3'b0};
            12'h305: return m_mtvec;
            12'h340: return m_mscr;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            12'hB02, 12'hC02: return m_ins[31:0];
            12'hB82, 12'hC82: return m_ins[63:32];
`ifdef SEGRE_CSR_MCOUNTINHIBIT_EN
            12'h320: return {29'b0, m_ir, 1'b0, m_cy};
`endif
            default: begin
                if (a >= 12'h7C0 && a < 12'h7C0 + 12'(NS))
                    return m_scr[a - 12'h7C0];
                return 32'h0;
            end
        endcase
    endfunction

    function automatic logic m_illegal(input logic [1:0] op,
                                       input logic [11:0] a,
                                       input logic [31:0] wd);
        logic wi;
        wi = (op == 2'b01) || (op != 2'b00 && wd != 0);
        return (op != 2'b00) && (!m_impl(a) || (wi && a[11:10] == 2'b11));
    endfunction

    task automatic m_update(input logic [1:0] op, input logic [11:0] a,
                            input logic [31:0] wd, input logic ir,
                            input logic tr, input logic [31:0] ep,
                            input logic [31:0] ca, input logic mr);
        logic [31:0] old, nv;
        logic        wi, we;
        old = m_read(a);
        wi  = (op == 2'b01) || (op != 2'b00 && wd != 0);
        we  = wi && !m_illegal(op, a, wd) && !tr;
        nv  = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
        if (we && a == 12'hB00) m_cyc = {m_cyc[63:32], nv};
        else if (we && a == 12'hB80) m_cyc = (({32'b0, nv} << 32) | {32'b0, m_cyc[31:0]}) & CMASK;
        else if (!m_cy) m_cyc = (m_cyc + 64'd1) & CMASK;
        if (we && a == 12'hB02) m_ins = {m_ins[63:32], nv};
        else if (we && a == 12'hB82) m_ins = (({32'b0, nv} << 32) | {32'b0, m_ins[31:0]}) & CMASK;
        else if (ir && !m_ir) m_ins = (m_ins + 64'd1) & CMASK;
        if (tr) begin
            m_mpie = m_mie; m_mie = 0;
            m_mepc = ep & 32'hFFFF_FFFC; m_mcause = ca;
        end else if (mr) begin
            m_mie = m_mpie; m_mpie = 1;
        end else if (we && a == 12'h300) begin
            m_mie = nv[3]; m_mpie = nv[7];
        end
        if (we) begin
            case (a)
                12'h305: m_mtvec = nv & 32'hFFFF_FFFC;
                12'h340: m_mscr = nv;
                12'h341: m_mepc = nv & 32'hFFFF_FFFC;
                12'h342: m_mcause = nv;
`ifdef SEGRE_CSR_MCOUNTINHIBIT_EN
                12'h320: begin m_cy = nv[0]; m_ir = nv[2]; end
`endif
                default: if (a >= 12'h7C0 && a < 12'h7C0 + 12'(NS)) m_scr[a - 12'h7C0] = nv;
            endcase
        end
    endtask

    logic [31:0] s_rd;
    logic        s_il;

    // Entered just after a falling edge; leaves at the next falling edge.
    task automatic step_full(input logic [1:0] op, input logic [11:0] a,
                             input logic [31:0] wd, input logic ir,
                             input logic tr, input logic [31:0] ep,
                             input logic [31:0] ca, input logic mr);
        bus.op_i = op; bus.addr_i = a; bus.wdata_i = wd;
        instret = ir; trap = tr; epc = ep; cause = ca; mret = mr;
        #1;
        s_rd = bus.rdata_o;
        s_il = bus.illegal_o;
        chk("model_rdata", s_rd, m_read(a));
        chk("model_illegal", {31'b0, s_il}, {31'b0, m_illegal(op, a, wd)});
        chk("model_mtvec", mtvec_w, m_mtvec);
        chk("model_mepc", mepc_w, m_mepc);
        chk("model_mie", {31'b0, mie_w}, {31'b0, m_mie});
        m_update(op, a, wd, ir, tr, ep, ca, mr);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input logic [1:0] op, input logic [11:0] a,
                        input logic [31:0] wd);
        step_full(op, a, wd, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [11:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        chk_rd;
        logic        il;
    } vec_t;

    vec_t tbl [$];
    logic [11:0] alist [$];
    logic [31:0] snap;

    initial begin
        bus.op_i = 2'b00; bus.addr_i = 12'h305; bus.wdata_i = '0;
        m_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("reset_rdata", bus.rdata_o, MTV);
        chk("reset_illegal", {31'b0, bus.illegal_o}, 32'h0);
        chk("reset_mtvec", mtvec_w, MTV);
        chk("reset_mepc", mepc_w, 32'h0);
        chk("reset_mie", {31'b0, mie_w}, 32'h0);
        @(negedge clk);
        rsn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            step(2'b10, 12'hB00, 32'h0);
            chk("cycle_after_reset", s_rd, 32'(i));
        end
        step(2'b10, 12'h305, 32'h0);
        chk("mtvec_read", s_rd, MTV);
        chk("mtvec_read_legal", {31'b0, s_il}, 32'h0);

        tbl.push_back('{2'b01, 12'h340, 32'hA5A5_0000, 32'h0,         1'b1, 1'b0});
        tbl.push_back('{2'b10, 12'h340, 32'h0000_00FF, 32'hA5A5_0000, 1'b1, 1'b0});
        tbl.push_back('{2'b11, 12'h340, 32'hA500_0000, 32'hA5A5_00FF, 1'b1, 1'b0});
        tbl.push_back('{2'b10, 12'h340, 32'h0,         32'h00A5_00FF, 1'b1, 1'b0});
        tbl.push_back('{2'b01, 12'hC00, 32'h1234,      32'h0,         1'b0, 1'b1});
        tbl.push_back('{2'b10, 12'hC00, 32'h0,         32'h0,         1'b0, 1'b0});
        tbl.push_back('{2'b11, 12'hC82, 32'h0,         32'h0,         1'b1, 1'b0});
        tbl.push_back('{2'b10, 12'hC82, 32'h1,         32'h0,         1'b1, 1'b1});
        tbl.push_back('{2'b01, 12'h123, 32'h5,         32'h0,         1'b1, 1'b1});
        tbl.push_back('{2'b00, 12'h123, 32'h5,         32'h0,         1'b1, 1'b0});
        tbl.push_back('{2'b01, 12'h301, 32'h5,         32'h0,         1'b1, 1'b1});
        tbl.push_back('{2'b01, 12'h305, 32'h0000_1237, MTV,           1'b1, 1'b0});
        tbl.push_back('{2'b10, 12'h305, 32'h0,         32'h0000_1234, 1'b1, 1'b0});
        tbl.push_back('{2'b01, 12'h7C1, 32'hDEAD_BEEF, 32'h0,         1'b1, 1'b0});
        tbl.push_back('{2'b10, 12'h7C1, 32'h0,         32'hDEAD_BEEF, 1'b1, 1'b0});
        tbl.push_back('{2'b01, 12'h7C2, 32'h1,         32'h0,         1'b1, 1'b1});
        tbl.push_back('{2'b01, 12'h300, 32'h0000_0088, 32'h0,         1'b1, 1'b0});
        tbl.push_back('{2'b10, 12'h300, 32'h0,         32'h0000_0088, 1'b1, 1'b0});
        tbl.push_back('{2'b01, 12'h300, 32'hFFFF_FFFF, 32'h0000_0088, 1'b1, 1'b0});
        tbl.push_back('{2'b11, 12'h300, 32'hFFFF_FFFF, 32'h0000_0088, 1'b1, 1'b0});
        tbl.push_back('{2'b10, 12'h300, 32'h0,         32'h0,         1'b1, 1'b0});
        foreach (tbl[i]) begin
            step(tbl[i].op, tbl[i].a, tbl[i].wd);
            if (tbl[i].chk_rd) chk($sformatf("vec%0d_rdata", i), s_rd, tbl[i].rd);
            chk($sformatf("vec%0d_illegal", i), {31'b0, s_il}, {31'b0, tbl[i].il});
        end

        // Carry from the low half into the high half
        step(2'b01, 12'hB00, 32'hFFFF_FFFE);
        step(2'b01, 12'hB80, 32'h0);
        step(2'b10, 12'hB00, 32'h0);
        chk("carry_hold_low", s_rd, 32'hFFFF_FFFE);
        step(2'b10, 12'hB00, 32'h0);
        chk("carry_pre", s_rd, 32'hFFFF_FFFF);
        step(2'b10, 12'hB00, 32'h0);
        chk("carry_low", s_rd, 32'h0);
        step(2'b10, 12'hB80, 32'h0);
        chk("carry_high", s_rd, 32'h1);

        // Full-width wrap of a 40-bit counter
        step(2'b01, 12'hB80, 32'hFFFF_FFFF);
        step(2'b01, 12'hB00, 32'hFFFF_FFFF);
        step(2'b10, 12'hC80, 32'h0);
        chk("cycle_high_masked", s_rd, 32'h0000_00FF);
        step(2'b10, 12'hB00, 32'h0);
        chk("cycle_wrap_low", s_rd, 32'h0);
        step(2'b10, 12'hB80, 32'h0);
        chk("cycle_wrap_high", s_rd, 32'h0);

        step_full(2'b01, 12'hB82, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 0, 1'b0);
        step_full(2'b01, 12'hB02, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 0, 1'b0);
        step_full(2'b10, 12'hC02, 32'h0, 1'b1, 1'b0, 0, 0, 1'b0);
        chk("instret_write_wins", s_rd, 32'hFFFF_FFFF);
        step(2'b10, 12'hC02, 32'h0);
        chk("instret_wrap", s_rd, 32'h0);
        step(2'b10, 12'hC02, 32'h0);
        chk("instret_idle", s_rd, 32'h0);

        // Trap entry with a concurrent dropped write, then MRET
        step(2'b01, 12'h340, 32'h0000_1111);
        step(2'b01, 12'h300, 32'h0000_0008);
        step_full(2'b01, 12'h340, 32'h2222, 1'b0, 1'b1, 32'h100, 32'hB, 1'b0);
        chk("trap_write_legal", {31'b0, s_il}, 32'h0);
        chk("trap_mepc", mepc_w, 32'h100);
        chk("trap_mie", {31'b0, mie_w}, 32'h0);
        step(2'b10, 12'h342, 32'h0);
        chk("trap_mcause", s_rd, 32'hB);
        step(2'b10, 12'h300, 32'h0);
        chk("trap_mstatus", s_rd, 32'h80);
        step(2'b10, 12'h340, 32'h0);
        chk("trap_mscratch_kept", s_rd, 32'h1111);
        step_full(2'b00, 12'h300, 32'h0, 1'b0, 1'b0, 0, 0, 1'b1);
        step(2'b10, 12'h300, 32'h0);
        chk("mret_mstatus", s_rd, 32'h88);
        step_full(2'b01, 12'h300, 32'h0, 1'b0, 1'b0, 0, 0, 1'b1);
        step(2'b10, 12'h300, 32'h0);
        chk("mret_beats_write", s_rd, 32'h88);
        step_full(2'b01, 12'h340, 32'h3333, 1'b0, 1'b0, 0, 0, 1'b1);
        step(2'b10, 12'h340, 32'h0);
        chk("mret_other_write", s_rd, 32'h3333);
        step_full(2'b00, 12'h0, 32'h0, 1'b0, 1'b1, 32'h207, 32'h8000_0003, 1'b1);
        chk("trap_epc_aligned", mepc_w, 32'h204);
        step(2'b10, 12'h300, 32'h0);
        chk("trap_beats_mret", s_rd, 32'h80);

`ifdef SEGRE_CSR_MCOUNTINHIBIT_EN
        step(2'b01, 12'h320, 32'hFFFF_FFFF);
        step(2'b10, 12'h320, 32'h0);
        chk("mcountinhibit_bits", s_rd, 32'h5);
        snap = m_cyc[31:0];
        for (int i = 0; i < 10; i++) begin
            step_full(2'b10, 12'hB00, 32'h0, 1'b1, 1'b0, 0, 0, 1'b0);
            chk("inhibit_cycle", s_rd, snap);
        end
        step(2'b10, 12'hB02, 32'h0);
        chk("inhibit_instret", s_rd, m_ins[31:0]);
        step(2'b01, 12'hB00, 32'h55);
        step(2'b10, 12'hB00, 32'h0);
        chk("inhibit_write", s_rd, 32'h55);
        step(2'b10, 12'hB00, 32'h0);
        chk("inhibit_write_hold", s_rd, 32'h55);
        step(2'b01, 12'h320, 32'h0);
`else
        step(2'b01, 12'h320, 32'h1);
        chk("mcountinhibit_absent", {31'b0, s_il}, 32'h1);
        chk("mcountinhibit_rdata", s_rd, 32'h0);
`endif

        alist = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h7C0,
                  12'h7C1, 12'h7C2, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                  12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h320, 12'h123};
        for (int i = 0; i < 3000; i++) begin
            logic [11:0] a;
            logic [31:0] wd;
            a  = alist[$urandom_range(0, alist.size() - 1)];
            wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            step_full(2'($urandom_range(0, 3)), a, wd,
                      1'($urandom_range(0, 1)),
                      $urandom_range(0, 15) == 0, $urandom, $urandom,
                      $urandom_range(0, 7) == 0);
        end

        // Asynchronous reset between clock edges
        step(2'b01, 12'h340, 32'hCAFE);
        bus.op_i = 2'b00; bus.addr_i = 12'h340; instret = 0; trap = 0; mret = 0;
        #2 rsn = 1'b0;
        #1;
        chk("async_rst_mscratch", bus.rdata_o, 32'h0);
        chk("async_rst_mtvec", mtvec_w, MTV);
        chk("async_rst_mepc", mepc_w, 32'h0);
        chk("async_rst_mie", {31'b0, mie_w}, 32'h0);
        m_reset();
        @(negedge clk);
        rsn = 1'b1;
        step(2'b10, 12'hB00, 32'h0);
        chk("cycle_after_rerst", s_rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
